// File: rtl/aes_pkg.sv
// Shared AES-128 arithmetic, key-schedule and inverse-round helpers, plus the decrypt FSM encoding.
// Pure combinational functions; S-boxes are derived from the GF(2^8) inverse and the affine map.
package aes_pkg;

    typedef logic [127:0] blk_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        DEC  = 2'd2,
        DONE = 2'd3
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic blk_t fwd_key(input blk_t k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h000000};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Recovers the previous round key from the current one
    function automatic blk_t inv_key(input blk_t k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
        {w4, w5, w6, w7} = k;
        w3 = w7 ^ w6;
        w2 = w6 ^ w5;
        w1 = w5 ^ w4;
        w0 = w4 ^ sub_rot_word(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    // Byte n sits at bits [127-8n -: 8]; state element (r,c) is byte r+4c
    function automatic blk_t inv_shift_rows(input blk_t s);
        blk_t o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c-r+4)%4))) +: 8];
            end
        end
        return o;
    endfunction

    function automatic blk_t inv_sub_bytes(input blk_t s);
        blk_t o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[8*(15-n) +: 8] = inv_sbox(s[8*(15-n) +: 8]);
        end
        return o;
    endfunction

    function automatic blk_t inv_mix_columns(input blk_t s);
        blk_t o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(15-4*c)   +: 8];
            a1 = s[8*(14-4*c)   +: 8];
            a2 = s[8*(13-4*c)   +: 8];
            a3 = s[8*(12-4*c)   +: 8];
            o[8*(15-4*c) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[8*(14-4*c) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[8*(13-4*c) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[8*(12-4*c) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES-128 inverse round plus one backward key-schedule step, purely combinational.
// No state and no handshake; the caller decides when to register st_nxt and kp.
import aes_pkg::*;

module aes_inv_round (
    input  logic [127:0] st,
    input  logic [127:0] kreg,
    input  logic [3:0]   rnd,
    output logic [127:0] st_nxt,
    output logic [127:0] kp
);

    logic [127:0] core;

    always_comb begin
        kp     = inv_key(kreg, rcon(rnd + 4'd1));
        core   = inv_sub_bytes(inv_shift_rows(st)) ^ kp;
        // the final round of the inverse cipher has no InvMixColumns
        st_nxt = (rnd == 4'd0) ? core : inv_mix_columns(core);
    end

endmodule

// File: rtl/aes_decrypt_128_iter.sv
// Iterative AES-128 decrypt: 21 edges accept-to-out_valid on a key miss, 11 on a cached-key hit.
// Accepts only in IDLE; result is held in DONE until out_ready is sampled high.
import aes_pkg::*;

module aes_decrypt_128_iter #(
    parameter bit CACHE_KEY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain,
    output logic         busy
);

    fsm_t         fsm, fsm_nxt;
    logic [127:0] st, kreg, c_key, c_k10;
    logic [3:0]   rnd;
    logic         c_vld;
    logic [127:0] k_fwd, st_dec, kp;
    logic         hit;

    assign hit   = CACHE_KEY && c_vld && (key == c_key);
    assign k_fwd = fwd_key(kreg, rcon(rnd));
    assign plain = st;

    aes_inv_round u_inv_round (
        .st     (st),
        .kreg   (kreg),
        .rnd    (rnd),
        .st_nxt (st_dec),
        .kp     (kp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt   = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_nxt = hit ? DEC : KEXP;
            end
            KEXP: begin
                busy = 1'b1;
                if (rnd == 4'd10) fsm_nxt = DEC;
            end
            DEC: begin
                busy = 1'b1;
                if (rnd == 4'd0) fsm_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= '0;
            kreg  <= '0;
            rnd   <= '0;
            c_key <= '0;
            c_k10 <= '0;
            c_vld <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        if (hit) begin
                            st   <= cipher ^ c_k10;
                            kreg <= c_k10;
                            rnd  <= 4'd9;
                        end else begin
                            // cache entry is rewritten now and revalidated once round key 10 exists
                            st    <= cipher;
                            kreg  <= key;
                            rnd   <= 4'd1;
                            c_key <= key;
                            c_vld <= 1'b0;
                        end
                    end
                end
                KEXP: begin
                    kreg <= k_fwd;
                    if (rnd == 4'd10) begin
                        st    <= st ^ k_fwd;
                        c_k10 <= k_fwd;
                        c_vld <= CACHE_KEY;
                        rnd   <= 4'd9;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DEC: begin
                    kreg <= kp;
                    st   <= st_dec;
                    if (rnd != 4'd0) rnd <= rnd - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_128_iter.sv
// Directed-vector bench for the iterative AES-128 decrypt core, cached and uncached builds.
module tb_aes_decrypt_128_iter;

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K10A = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K10B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk, rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] cipher, key, plain;
    logic         in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [127:0] cipher2, key2, plain2;

    int checks = 0;
    int errors = 0;

    aes_decrypt_128_iter #(.CACHE_KEY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cipher(cipher), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .plain(plain), .busy(busy)
    );

    aes_decrypt_128_iter #(.CACHE_KEY(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .cipher(cipher2), .key(key2), .out_valid(out_valid2), .out_ready(out_ready2),
        .plain(plain2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Drives one block into an idle core, measures accept-to-out_valid edges, then consumes the result
    task automatic run_block(input bit nc, input logic [127:0] k, input logic [127:0] c,
                             output logic [127:0] p, output int lat);
        @(negedge clk);
        if (nc) begin in_valid2 = 1'b1; key2 = k; cipher2 = c; end
        else    begin in_valid  = 1'b1; key  = k; cipher  = c; end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        lat = 1;
        while (!(nc ? out_valid2 : out_valid) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        p = nc ? plain2 : plain;
        out_ready  = 1'b1;
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready  = 1'b0;
        out_ready2 = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (plain !== 128'h0)    begin errors++; $display("FAIL reset_plain: got %h want 0", plain); end
        checks++; if (dut.c_vld !== 1'b0)  begin errors++; $display("FAIL reset_c_vld: got %b want 0", dut.c_vld); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_miss_first;
        logic [127:0] p;
        int lat;
        run_block(1'b0, K1, C1, p, lat);
        checks++; if (p !== P1)          begin errors++; $display("FAIL miss1_plain: got %h want %h", p, P1); end
        checks++; if (lat !== 21)        begin errors++; $display("FAIL miss1_latency: got %0d want 21", lat); end
        checks++; if (dut.c_k10 !== K10A) begin errors++; $display("FAIL miss1_c_k10: got %h want %h", dut.c_k10, K10A); end
        checks++; if (dut.c_vld !== 1'b1) begin errors++; $display("FAIL miss1_c_vld: got %b want 1", dut.c_vld); end
    endtask

    task automatic test_hit;
        logic [127:0] p;
        int lat;
        run_block(1'b0, K1, C1, p, lat);
        checks++; if (p !== P1)   begin errors++; $display("FAIL hit_plain: got %h want %h", p, P1); end
        checks++; if (lat !== 11) begin errors++; $display("FAIL hit_latency: got %0d want 11", lat); end
    endtask

    task automatic test_miss_second;
        logic [127:0] p;
        int lat;
        run_block(1'b0, K2, C2, p, lat);
        checks++; if (p !== P2)           begin errors++; $display("FAIL miss2_plain: got %h want %h", p, P2); end
        checks++; if (lat !== 21)         begin errors++; $display("FAIL miss2_latency: got %0d want 21", lat); end
        checks++; if (dut.c_k10 !== K10B) begin errors++; $display("FAIL miss2_c_k10: got %h want %h", dut.c_k10, K10B); end
    endtask

    task automatic test_backpressure;
        int lat;
        @(negedge clk);
        in_valid = 1'b1; key = K2; cipher = C2;
        @(posedge clk); #1;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 11) begin errors++; $display("FAIL bp_latency: got %0d want 11", lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (plain !== P2)       begin errors++; $display("FAIL bp_plain_stable[%0d]: got %h want %h", i, plain, P2); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_idle_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL bp_idle_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_second_accept: got busy %b want 1", busy); end
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 11)   begin errors++; $display("FAIL bp_second_latency: got %0d want 11", lat); end
        checks++; if (plain !== P2) begin errors++; $display("FAIL bp_second_plain: got %h want %h", plain, P2); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_dec;
        logic [127:0] p;
        int lat;
        // prime the cache with K1 so the post-reset run would hit if the cache survived
        run_block(1'b0, K1, C1, p, lat);
        checks++; if (lat !== 21) begin errors++; $display("FAIL rst_prime_latency: got %0d want 21", lat); end
        @(negedge clk);
        in_valid = 1'b1; key = K1; cipher = C1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (dut.rnd !== 4'd5) begin errors++; $display("FAIL rst_mid_rnd: got %0d want 5", dut.rnd); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL rst_mid_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (plain !== 128'h0)   begin errors++; $display("FAIL rst_plain: got %h want 0", plain); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (dut.c_vld !== 1'b0) begin errors++; $display("FAIL rst_c_vld: got %b want 0", dut.c_vld); end
        @(negedge clk);
        rst_n = 1'b1;
        run_block(1'b0, K1, C1, p, lat);
        checks++; if (p !== P1)   begin errors++; $display("FAIL rst_resend_plain: got %h want %h", p, P1); end
        checks++; if (lat !== 21) begin errors++; $display("FAIL rst_resend_latency: got %0d want 21", lat); end
    endtask

    task automatic test_no_cache;
        logic [127:0] p;
        int lat;
        for (int i = 0; i < 2; i++) begin
            run_block(1'b1, K1, C1, p, lat);
            checks++; if (p !== P1)   begin errors++; $display("FAIL nocache_plain[%0d]: got %h want %h", i, p, P1); end
            checks++; if (lat !== 21) begin errors++; $display("FAIL nocache_latency[%0d]: got %0d want 21", i, lat); end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;  key = '0;  cipher = '0;  out_ready = 1'b0;
        in_valid2 = 1'b0; key2 = '0; cipher2 = '0; out_ready2 = 1'b0;
        test_reset;
        test_miss_first;
        test_hit;
        test_miss_second;
        test_backpressure;
        test_reset_mid_dec;
        test_no_cache;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
